// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch stage of the 5-stage core. It drives the fetch address
// and chip-enable to the instruction ROM and captures the returned word,
// together with its address, into the IF/ID pipeline register.
//
// Ports:
//   clk                      core clock, rising-edge
//   rst                      synchronous reset, active-low
//   stall[5:0]               stall vector: bit0 PC, bit1 IF, bit2 ID
//   flush, new_pc            pipeline flush and its redirect address
//   branch_flag_i            ID resolved a taken branch/jump
//   branch_target_address_i  target of that branch/jump
//   inst_i                   ROM instruction word for pc
//   pc, ce                   fetch address and ROM chip-enable
//   id_pc, id_inst           IF/ID pipeline register
//   fetch_cnt                instructions passed into IF/ID (wraps)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       stall,
   input  logic             flush,
   input  logic [31:0]      new_pc,
   input  logic             branch_flag_i,
   input  logic [31:0]      branch_target_address_i,
   input  logic [31:0]      inst_i,
   output logic [31:0]      pc,
   output logic             ce,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_inst,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [31:0]      PC_INC  = 32'(PC_STEP);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_reg, state_next;
   logic [31:0]      pc_reg, pc_next;
   logic             pending_valid_reg, pending_valid_next;
   logic [31:0]      pending_target_reg, pending_target_next;
   logic [31:0]      id_pc_reg, id_pc_next;
   logic [31:0]      id_inst_reg, id_inst_next;
   logic [CNT_W-1:0] fetch_cnt_reg, fetch_cnt_next;

   // Only the PC/IF/ID stall bits concern this stage.
   logic unused_stall_bits;
   assign unused_stall_bits = &{1'b0, stall[5:3]};

   // Chip-enable is a pure function of state so the ROM is never enabled
   // during the post-reset idle cycle.
   assign ce = (state_reg == RUN);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg          <= IDLE;
         pc_reg             <= RESET_PC;
         pending_valid_reg  <= 1'b0;
         pending_target_reg <= 32'h0;
         id_pc_reg          <= 32'h0;
         id_inst_reg        <= 32'h0;
         fetch_cnt_reg      <= '0;
      end else begin
         state_reg          <= state_next;
         pc_reg             <= pc_next;
         pending_valid_reg  <= pending_valid_next;
         pending_target_reg <= pending_target_next;
         id_pc_reg          <= id_pc_next;
         id_inst_reg        <= id_inst_next;
         fetch_cnt_reg      <= fetch_cnt_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      pc_next             = pc_reg;
      pending_valid_next  = pending_valid_reg;
      pending_target_next = pending_target_reg;
      id_pc_next          = id_pc_reg;
      id_inst_next        = id_inst_reg;
      fetch_cnt_next      = fetch_cnt_reg;

      case (state_reg)
         IDLE: begin
            // First cycle out of reset: enable the ROM, first fetch is at
            // RESET_PC on the following cycle.
            state_next = RUN;
         end

         RUN: begin
            // PC selection. A branch seen while the PC is stalled is parked
            // in the pending slot so it is not lost; only the first one is
            // kept until it is applied or a flush discards it.
            if (flush) begin
               pc_next            = new_pc;
               pending_valid_next = 1'b0;
            end else if (stall[0]) begin
               if (branch_flag_i && !pending_valid_reg) begin
                  pending_target_next = branch_target_address_i;
                  pending_valid_next  = 1'b1;
               end
            end else if (pending_valid_reg) begin
               pc_next            = pending_target_reg;
               pending_valid_next = 1'b0;
            end else if (branch_flag_i) begin
               pc_next = branch_target_address_i;
            end else begin
               pc_next = pc_reg + PC_INC;
            end

            // IF/ID register. IF stalled while ID runs means ID must see a
            // bubble rather than re-decode the held instruction.
            if (flush) begin
               id_pc_next   = 32'h0;
               id_inst_next = 32'h0;
            end else if (stall[1] && !stall[2]) begin
               id_pc_next   = 32'h0;
               id_inst_next = 32'h0;
            end else if (!stall[1]) begin
               id_pc_next   = pc_reg;
               id_inst_next = ce ? inst_i : 32'h0;
            end

            if (ce && !stall[1] && !flush) begin
               fetch_cnt_next = fetch_cnt_reg + CNT_ONE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign pc        = pc_reg;
   assign id_pc     = id_pc_reg;
   assign id_inst   = id_inst_reg;
   assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage. The ROM returns 32'h1000_0000 + (pc>>2)
// for each address. Inputs change 1 time unit after the rising edge; outputs
// are checked at that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic [31:0] inst_i;
   logic [31:0] pc;
   logic        ce;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // ROM model
   assign inst_i = 32'h1000_0000 + (pc >> 2);

   if_fetch_stage #(
      .RESET_PC(32'h0000_0000),
      .PC_STEP (4),
      .CNT_W   (32)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .inst_i                  (inst_i),
      .pc                      (pc),
      .ce                      (ce),
      .id_pc                   (id_pc),
      .id_inst                 (id_inst),
      .fetch_cnt               (fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One line per transaction: checks pc, ce, id_pc, id_inst and fetch_cnt.
   task automatic expect_all(input string tag, input logic [31:0] e_pc, input logic e_ce,
                             input logic [31:0] e_id_pc, input logic [31:0] e_id_inst,
                             input logic [31:0] e_cnt);
      $display("%-14s pc=%h ce=%0b id_pc=%h id_inst=%h cnt=%0d",
               tag, pc, ce, id_pc, id_inst, fetch_cnt);
      chk({tag, ".pc"},      pc,           e_pc);
      chk({tag, ".ce"},      {31'h0, ce},  {31'h0, e_ce});
      chk({tag, ".id_pc"},   id_pc,        e_id_pc);
      chk({tag, ".id_inst"}, id_inst,      e_id_inst);
      chk({tag, ".cnt"},     fetch_cnt,    e_cnt);
   endtask

   initial begin
      rst = 1'b0; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
      branch_flag_i = 1'b0; branch_target_address_i = 32'h0;

      // Reset
      step(); step();
      expect_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);

      // Release: one IDLE cycle, then sequential fetch
      rst = 1'b1;
      step(); expect_all("idle2run", 32'h0, 1'b1, 32'h0, 32'h0, 32'd0);
      step(); expect_all("seq0",  32'h4, 1'b1, 32'h0, 32'h1000_0000, 32'd1);
      step(); expect_all("seq1",  32'h8, 1'b1, 32'h4, 32'h1000_0001, 32'd2);
      step(); expect_all("seq2",  32'hC, 1'b1, 32'h8, 32'h1000_0002, 32'd3);

      // Branch resolved while the instruction at 8 is in ID
      branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
      step(); expect_all("br_tgt", 32'h40, 1'b1, 32'hC, 32'h1000_0003, 32'd4);
      branch_flag_i = 1'b0;
      step(); expect_all("br_next", 32'h44, 1'b1, 32'h40, 32'h1000_0010, 32'd5);

      // Flush to 0xC so that pc reaches 16 with a live IF/ID entry
      flush = 1'b1; new_pc = 32'hC;
      step(); expect_all("flush_c", 32'hC, 1'b1, 32'h0, 32'h0, 32'd5);
      flush = 1'b0;
      step(); expect_all("to16", 32'h10, 1'b1, 32'hC, 32'h1000_0003, 32'd6);

      // Full stall for three cycles
      stall = 6'b000111;
      for (int i = 0; i < 3; i++) begin
         step(); expect_all("stall_hold", 32'h10, 1'b1, 32'hC, 32'h1000_0003, 32'd6);
      end
      stall = 6'b0;
      step(); expect_all("stall_rel", 32'h14, 1'b1, 32'h10, 32'h1000_0004, 32'd7);

      // IF stalled, ID running: bubble
      stall = 6'b000011;
      step(); expect_all("bubble", 32'h14, 1'b1, 32'h0, 32'h0, 32'd7);

      // Branch during PC stall is parked; a second one is ignored
      stall = 6'b000111; branch_flag_i = 1'b1; branch_target_address_i = 32'h80;
      step(); expect_all("pend_cap", 32'h14, 1'b1, 32'h0, 32'h0, 32'd7);
      branch_target_address_i = 32'h200;
      step(); expect_all("pend_ign", 32'h14, 1'b1, 32'h0, 32'h0, 32'd7);
      branch_flag_i = 1'b0;
      stall = 6'b0;
      step(); expect_all("pend_apply", 32'h80, 1'b1, 32'h14, 32'h1000_0005, 32'd8);
      step(); expect_all("pend_next", 32'h84, 1'b1, 32'h80, 32'h1000_0020, 32'd9);

      // Flush concurrent with branch: flush wins
      flush = 1'b1; new_pc = 32'h20; branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
      step(); expect_all("flush_br", 32'h20, 1'b1, 32'h0, 32'h0, 32'd9);
      flush = 1'b0; branch_flag_i = 1'b0;
      step(); expect_all("flush_nojmp", 32'h24, 1'b1, 32'h20, 32'h1000_0008, 32'd10);

      // Flush discards a parked branch
      stall = 6'b000111; branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
      step(); expect_all("pend2_cap", 32'h24, 1'b1, 32'h20, 32'h1000_0008, 32'd10);
      branch_flag_i = 1'b0; flush = 1'b1; new_pc = 32'h20;
      step(); expect_all("pend2_flush", 32'h20, 1'b1, 32'h0, 32'h0, 32'd10);
      flush = 1'b0; stall = 6'b0;
      step(); expect_all("pend2_gone", 32'h24, 1'b1, 32'h20, 32'h1000_0008, 32'd11);

      // Reset while a branch is parked
      stall = 6'b000111; branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
      step(); expect_all("pend3_cap", 32'h24, 1'b1, 32'h20, 32'h1000_0008, 32'd11);
      rst = 1'b0; stall = 6'b0; branch_flag_i = 1'b0;
      step(); expect_all("rst_mid", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
      rst = 1'b1;
      step(); expect_all("rst_idle", 32'h0, 1'b1, 32'h0, 32'h0, 32'd0);
      step(); expect_all("rst_seq", 32'h4, 1'b1, 32'h0, 32'h1000_0000, 32'd1);

      // PC wrap at the top of the address space
      flush = 1'b1; new_pc = 32'hFFFF_FFFC;
      step(); expect_all("wrap_set", 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0, 32'd1);
      flush = 1'b0;
      step(); expect_all("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
